// File: rtl/display_scan_controller_if.sv
// Bus bundle between the operand/result registers and the display scanner.
// The master drives scan control and data. The slave (the scanner) drives the decoder and digit pins.
interface display_scan_controller_if #(
   parameter int DIGITS = 4
);
   logic                  enable;
   logic                  load;
   logic [4*DIGITS-1:0]   data_in;
   logic [DIGITS-1:0]     blank_mask;
   logic [3:0]            nibble;
   logic [DIGITS-1:0]     sel;
   logic                  pending;
   logic                  frame_tick;

   modport master (
      output enable, load, data_in, blank_mask,
      input  nibble, sel, pending, frame_tick
   );

   modport slave (
      input  enable, load, data_in, blank_mask,
      output nibble, sel, pending, frame_tick
   );
endinterface

// File: rtl/display_scan_controller.sv
// Time-multiplexed digit scanner feeding one shared hex-to-7-segment decoder.
// Every digit slot begins with a short blanking phase. Loaded data is double-buffered
// and swapped in only at frame boundaries, so a frame never shows a mix of old and new digits.
module display_scan_controller #(
   parameter int DIGITS       = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                       clk,
   input  logic                       rst_n,
   display_scan_controller_if.slave   bus
);
   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [IW-1:0] DIGIT_LAST = IW'(DIGITS - 1);

   typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

   // With no blanking interval configured, a slot opens straight into SHOW
   localparam state_t SLOT_START = (BLANK_CYCLES == 0) ? SHOW : BLANK;

   state_t              state_reg, state_next;
   logic [CW-1:0]       cnt_reg, cnt_next;
   logic [IW-1:0]       idx_reg, idx_next;
   logic [4*DIGITS-1:0] active_reg;
   logic [4*DIGITS-1:0] pend_buf_reg;
   logic                pending_reg;
   logic [DIGITS-1:0]   sel_reg;
   logic [3:0]          nibble_reg;
   logic                frame_tick_reg;

   // State, slot counter and digit index registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         idx_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         idx_reg   <= idx_next;
      end
   end

   // Next-state logic: dropping enable parks the scan at digit 0, counter 0
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      idx_next   = idx_reg;
      if (!bus.enable) begin
         state_next = IDLE;
         cnt_next   = '0;
         idx_next   = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               state_next = SLOT_START;
               cnt_next   = '0;
               idx_next   = '0;
            end
            default: begin
               if (cnt_reg == SLOT_LAST) begin
                  cnt_next   = '0;
                  idx_next   = (idx_reg == DIGIT_LAST) ? '0 : idx_reg + 1'b1;
                  state_next = SLOT_START;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
                  if (state_reg == BLANK && cnt_reg == BLANK_LAST) begin
                     state_next = SHOW;
                  end
               end
            end
         endcase
      end
   end

   // Registered pin outputs; frame_tick is timed from the next-state values so it lines up with the last slot cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_reg        <= '1;
         nibble_reg     <= '0;
         frame_tick_reg <= 1'b0;
      end else begin
         sel_reg <= '1;
         if (bus.enable && state_reg == SHOW && !bus.blank_mask[idx_reg]) begin
            sel_reg <= ~(DIGITS'(1) << idx_reg);
         end
         if (state_reg != IDLE && cnt_reg == '0) begin
            nibble_reg <= active_reg[{idx_reg, 2'b00} +: 4];
         end
         frame_tick_reg <= (state_next != IDLE) && (cnt_next == SLOT_LAST) && (idx_next == DIGIT_LAST);
      end
   end

   // Double buffer: loads wait in pend_buf_reg until a frame boundary or until the scan is disabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_reg   <= '0;
         pend_buf_reg <= '0;
         pending_reg  <= 1'b0;
      end else if (bus.load && frame_tick_reg) begin
         active_reg  <= bus.data_in;
         pending_reg <= 1'b0;
      end else if (bus.load) begin
         pend_buf_reg <= bus.data_in;
         pending_reg  <= 1'b1;
      end else if (pending_reg && (frame_tick_reg || !bus.enable)) begin
         active_reg  <= pend_buf_reg;
         pending_reg <= 1'b0;
      end
   end

   assign bus.sel        = sel_reg;
   assign bus.nibble     = nibble_reg;
   assign bus.pending    = pending_reg;
   assign bus.frame_tick = frame_tick_reg;
endmodule
